mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Arbiter that shares the CPU's single memory port between the instruction-fetch path and the load/store path of `top`. It accepts one request per requester, serialises them onto the memory at one outstanding transaction at a time, and returns a response per port. Fixed read latency is hidden behind a valid pulse. It sits between the core's fetch/LSU logic and the unified instruction/data RAM.

## Interface
- `WIDTH`, 32, data width; must be a multiple of 8.
- `AW`, 32, address width.
- `MEM_LAT`, 1, memory cycles from enable to read data valid; legal range is 1..4.

- `iClk` in 1: clock; all logic is on the rising edge.
- `iRst` in 1: reset, **synchronous, active-high**.
- `iFetchReq` in 1: fetch read request; held until `oFetchGnt`.
- `iFetchAddr` in AW: fetch address; stable while `iFetchReq` is high.
- `oFetchGnt` out 1: one-cycle grant pulse.
- `oFetchValid` out 1: one-cycle response pulse.
- `oFetchData` out WIDTH: fetched word; holds until the next fetch response.
- `iDataReq` in 1: load/store request; held until `oDataGnt`.
- `iDataWe` in 1: 1 = store, 0 = load.
- `iDataAddr` in AW: load/store address.
- `iDataWdata` in WIDTH: store data.
- `iDataBe` in WIDTH/8: store byte enables.
- `oDataGnt` out 1: one-cycle grant pulse.
- `oDataValid` out 1: one-cycle completion pulse, for both loads and stores.
- `oDataRdata` out WIDTH: load data; holds until the next load response.
- `oMemEn`, `oMemWe` out 1: memory enable and write enable.
- `oMemAddr` out AW, `oMemWdata` out WIDTH, `oMemBe` out WIDTH/8: memory command.
- `iMemRdata` in WIDTH: memory read data, valid `MEM_LAT` cycles after `oMemEn`.
- `oBusy` out 1: high whenever the state is not IDLE.

## Operation
- The FSM has four states: IDLE, ISSUE, WAIT, RESP.
- **Arbitration.** Arbitration is evaluated in IDLE and in RESP.
  - If any request is pending, latch the winner id and the winner's command (addr, we, wdata, be) into registers, then go to ISSUE.
  - Otherwise go to (or stay in) IDLE.
  - A fetch command latches we=0 and be=all ones.
- **ISSUE (one cycle).**
  - `oMemEn`=1, with `oMemWe`/`oMemAddr`/`oMemWdata`/`oMemBe` driven from the latched registers.
  - The winner's `Gnt`=1.
  - Load the latency counter with `MEM_LAT`, then go to WAIT.
- **WAIT.** Decrement the counter each cycle.
  - When the counter reaches 1, capture `iMemRdata` into the winner's data register (loads and fetches only) and go to RESP.
  - Stores ignore `iMemRdata`.
- **RESP (one cycle).** The winner's `Valid`=1, and arbitration for the next transaction happens in the same cycle.
- Memory outputs are 0 outside ISSUE, so `oMemEn` is a clean one-cycle pulse.
- **Priority.** Default is fixed priority: data beats fetch.
- **Requester rules.**
  - A requester may drop `Req` in the cycle after `Gnt`.
  - A `Req` still high in that cycle is treated as a new request.

## Timing
- **Reset values.**
  - Every output is 0, the state is IDLE, and the counter is 0.
  - Both data registers are 0.
  - The last-winner register points to data.
- **Latency.**
  - A request sampled in cycle t gives `Gnt` and `oMemEn` in t+1.
  - The response is in t+1+`MEM_LAT`+1 (for example t+3 when `MEM_LAT`=1).
- **Throughput.** One transaction per `MEM_LAT`+2 cycles under back-to-back requests, because RESP hands off directly to ISSUE.
- **Simultaneous requests.** Exactly one grant is issued per ISSUE; the loser keeps waiting with its `Req` held.
- **Reset mid-transaction.** The transaction is dropped, and no `Valid` or `Gnt` is emitted from the reset cycle onward. The memory may already have performed a write.
- **Requests during a transaction.** A request arriving during ISSUE or WAIT is not granted until the next RESP decision.
- **`MEM_LAT`=1.** WAIT lasts exactly one cycle.

## Configuration
- `MEM_ARB_ROUND_ROBIN_EN` defined: when both requesters are pending, grant the one that was not the last winner.
  - The last-winner register is updated on every grant.
  - After reset, fetch wins the first tie.
- `MEM_ARB_ROUND_ROBIN_EN` not defined: strict data-over-fetch priority, and the last-winner register is not instantiated.

## Structure
- Package `mem_arb_pkg`:
  - the state enum (IDLE/ISSUE/WAIT/RESP);
  - the requester id enum (REQ_FETCH/REQ_DATA);
  - the latency counter width constant (3 bits).
- Sub-module `mem_arb_pick`: combinational winner select. It takes the two requests and the last-winner id and returns the winner id plus an any-request flag, and it holds the `ifdef`.
- Everything else (FSM, counter, command and data registers) lives in `mem_port_arbiter`.

## Test plan
- **Single fetch.** Reset, then `iFetchReq`=1 with addr 0x10 at t, memory returns 0xDEADBEEF, `MEM_LAT`=1. Expect:
  - `oFetchGnt` and `oMemEn` at t+1 with `oMemAddr`=0x10;
  - `oFetchValid` at t+3 with `oFetchData`=0xDEADBEEF.
- **Store.** `iDataReq`/`iDataWe`=1, addr 0x20, wdata 0x12345678, be 0x3. Expect:
  - `oMemWe`=1, `oMemBe`=0x3 for one cycle;
  - `oDataValid` at t+3;
  - `oDataRdata` unchanged.
- **Simultaneous, fixed priority.** Both requests held. Expect the data grant first, then fetch granted in the RESP cycle plus 1, i.e. at t+4.
- **Simultaneous, round robin** (macro defined). Requests held continuously for 4 transactions. Expect grants in the order fetch, data, fetch, data.
- **Reset mid-operation.** `iRst`=1 during WAIT. Expect:
  - no `Valid` pulse;
  - `oBusy`=0 the following cycle;
  - a new fetch after release completes normally.
- **`MEM_LAT`=4.** A load completes with `oDataValid` exactly 6 cycles after the request and `oBusy` high for 6 cycles.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the memory port arbiter.
//   state_e  : arbiter FSM states (IDLE/ISSUE/WAIT/RESP)
//   req_id_e : requester identity (REQ_FETCH/REQ_DATA)
//   CNT_W    : width of the read-latency counter (holds MEM_LAT up to 4)
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  typedef enum logic {
    REQ_FETCH = 1'b0,
    REQ_DATA  = 1'b1
  } req_id_e;

  localparam int unsigned CNT_W = 3;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select for the memory port arbiter.
//   fetch_req, data_req : pending requests from the two requesters
//   last_win            : requester granted most recently
//   win_id              : selected requester (meaningful when any_req is high)
//   any_req             : at least one request is pending
// Build option MEM_ARB_ROUND_ROBIN_EN: on a tie, pick the requester that did
// not win last time. Without it, data always beats fetch and last_win is
// ignored.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic    fetch_req,
  input  logic    data_req,
  input  req_id_e last_win,
  output req_id_e win_id,
  output logic    any_req
);

  assign any_req = fetch_req | data_req;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  always_comb begin
    win_id = REQ_DATA;
    if (fetch_req && data_req) begin
      win_id = (last_win == REQ_DATA) ? REQ_FETCH : REQ_DATA;
    end else if (fetch_req) begin
      win_id = REQ_FETCH;
    end
  end
`else
  logic unused_last_win;
  assign unused_last_win = last_win;

  // Data wins whenever it is asking; fetch only when data is quiet.
  assign win_id = (data_req || !fetch_req) ? REQ_DATA : REQ_FETCH;
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the instruction-fetch and load/store paths.
// One transaction is in flight at a time: IDLE/RESP pick a winner and latch
// its command, ISSUE drives the memory for one cycle and pulses the grant,
// WAIT counts down the fixed read latency and captures read data, RESP
// pulses the response valid while already arbitrating for the next request.
// All outputs are registered.
// Ports:
//   iClk, iRst                      : clock, synchronous active-high reset
//   iFetch*/oFetch*                 : fetch read request, grant, response
//   iData*/oData*                   : load/store request, grant, response
//   oMem*/iMemRdata                 : memory command and read data
//   oBusy                           : FSM is not IDLE
// Build option MEM_ARB_ROUND_ROBIN_EN: alternate the winner on ties using a
// last-winner register (reset to data, so fetch wins the first tie).
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned AW      = 32,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic               iClk,
  input  logic               iRst,
  input  logic               iFetchReq,
  input  logic [AW-1:0]      iFetchAddr,
  output logic               oFetchGnt,
  output logic               oFetchValid,
  output logic [WIDTH-1:0]   oFetchData,
  input  logic               iDataReq,
  input  logic               iDataWe,
  input  logic [AW-1:0]      iDataAddr,
  input  logic [WIDTH-1:0]   iDataWdata,
  input  logic [WIDTH/8-1:0] iDataBe,
  output logic               oDataGnt,
  output logic               oDataValid,
  output logic [WIDTH-1:0]   oDataRdata,
  output logic               oMemEn,
  output logic               oMemWe,
  output logic [AW-1:0]      oMemAddr,
  output logic [WIDTH-1:0]   oMemWdata,
  output logic [WIDTH/8-1:0] oMemBe,
  input  logic [WIDTH-1:0]   iMemRdata,
  output logic               oBusy
);

  localparam int unsigned BEW = WIDTH / 8;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  req_id_e          win_q, win_d;
  logic             cmd_we_q, cmd_we_d;
  logic [AW-1:0]    cmd_addr_q, cmd_addr_d;
  logic [WIDTH-1:0] cmd_wdata_q, cmd_wdata_d;
  logic [BEW-1:0]   cmd_be_q, cmd_be_d;
  logic [WIDTH-1:0] fetch_data_q, fetch_data_d;
  logic [WIDTH-1:0] data_rdata_q, data_rdata_d;

  logic             fetch_gnt_q, fetch_gnt_d;
  logic             data_gnt_q, data_gnt_d;
  logic             fetch_valid_q, fetch_valid_d;
  logic             data_valid_q, data_valid_d;
  logic             mem_en_q, mem_en_d;
  logic             mem_we_q, mem_we_d;
  logic [AW-1:0]    mem_addr_q, mem_addr_d;
  logic [WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [BEW-1:0]   mem_be_q, mem_be_d;
  logic             busy_q, busy_d;

  req_id_e          last_win;
  req_id_e          pick_id;
  logic             any_req;
  logic             issue_d;
  logic             resp_d;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  req_id_e last_win_q, last_win_d;
  assign last_win = last_win_q;
`else
  assign last_win = REQ_DATA;
`endif

  mem_arb_pick u_pick (
    .fetch_req (iFetchReq),
    .data_req  (iDataReq),
    .last_win  (last_win),
    .win_id    (pick_id),
    .any_req   (any_req)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    win_d        = win_q;
    cmd_we_d     = cmd_we_q;
    cmd_addr_d   = cmd_addr_q;
    cmd_wdata_d  = cmd_wdata_q;
    cmd_be_d     = cmd_be_q;
    fetch_data_d = fetch_data_q;
    data_rdata_d = data_rdata_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    last_win_d   = last_win_q;
`endif

    case (state_q)
      // RESP arbitrates exactly like IDLE so back-to-back requests go
      // straight to ISSUE without an idle bubble.
      IDLE, RESP: begin
        if (any_req) begin
          state_d = ISSUE;
          win_d   = pick_id;
`ifdef MEM_ARB_ROUND_ROBIN_EN
          last_win_d = pick_id;
`endif
          if (pick_id == REQ_DATA) begin
            cmd_we_d    = iDataWe;
            cmd_addr_d  = iDataAddr;
            cmd_wdata_d = iDataWdata;
            cmd_be_d    = iDataBe;
          end else begin
            cmd_we_d    = 1'b0;
            cmd_addr_d  = iFetchAddr;
            cmd_wdata_d = '0;
            cmd_be_d    = '1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        cnt_d   = CNT_W'(MEM_LAT);
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        // The last WAIT cycle is the one where read data is valid.
        if (cnt_q == CNT_W'(1)) begin
          state_d = RESP;
          if (!cmd_we_q) begin
            if (win_q == REQ_FETCH) begin
              fetch_data_d = iMemRdata;
            end else begin
              data_rdata_d = iMemRdata;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they appear registered in
    // the cycle the FSM occupies that state.
    issue_d       = (state_d == ISSUE);
    resp_d        = (state_d == RESP);
    fetch_gnt_d   = issue_d && (win_d == REQ_FETCH);
    data_gnt_d    = issue_d && (win_d == REQ_DATA);
    fetch_valid_d = resp_d && (win_d == REQ_FETCH);
    data_valid_d  = resp_d && (win_d == REQ_DATA);
    mem_en_d      = issue_d;
    mem_we_d      = issue_d && cmd_we_d;
    mem_addr_d    = issue_d ? cmd_addr_d  : '0;
    mem_wdata_d   = issue_d ? cmd_wdata_d : '0;
    mem_be_d      = issue_d ? cmd_be_d    : '0;
    busy_d        = (state_d != IDLE);
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      win_q         <= REQ_DATA;
      cmd_we_q      <= 1'b0;
      cmd_addr_q    <= '0;
      cmd_wdata_q   <= '0;
      cmd_be_q      <= '0;
      fetch_data_q  <= '0;
      data_rdata_q  <= '0;
      fetch_gnt_q   <= 1'b0;
      data_gnt_q    <= 1'b0;
      fetch_valid_q <= 1'b0;
      data_valid_q  <= 1'b0;
      mem_en_q      <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      mem_be_q      <= '0;
      busy_q        <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_win_q    <= REQ_DATA;
`endif
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      win_q         <= win_d;
      cmd_we_q      <= cmd_we_d;
      cmd_addr_q    <= cmd_addr_d;
      cmd_wdata_q   <= cmd_wdata_d;
      cmd_be_q      <= cmd_be_d;
      fetch_data_q  <= fetch_data_d;
      data_rdata_q  <= data_rdata_d;
      fetch_gnt_q   <= fetch_gnt_d;
      data_gnt_q    <= data_gnt_d;
      fetch_valid_q <= fetch_valid_d;
      data_valid_q  <= data_valid_d;
      mem_en_q      <= mem_en_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      mem_be_q      <= mem_be_d;
      busy_q        <= busy_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_win_q    <= last_win_d;
`endif
    end
  end

  assign oFetchGnt   = fetch_gnt_q;
  assign oFetchValid = fetch_valid_q;
  assign oFetchData  = fetch_data_q;
  assign oDataGnt    = data_gnt_q;
  assign oDataValid  = data_valid_q;
  assign oDataRdata  = data_rdata_q;
  assign oMemEn      = mem_en_q;
  assign oMemWe      = mem_we_q;
  assign oMemAddr    = mem_addr_q;
  assign oMemWdata   = mem_wdata_q;
  assign oMemBe      = mem_be_q;
  assign oBusy       = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a MEM_LAT=1 instance checked every cycle
// against a transaction-level model, plus a MEM_LAT=4 instance sharing the
// requester inputs for the long-latency case. Each instance has its own
// behavioural RAM that returns random data whenever no read is in flight.
module tb_mem_port_arbiter;

  localparam int LAT1 = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_init = 1'b1;
  logic        f_req = 1'b0;
  logic [31:0] f_addr = '0;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [3:0]  d_be = '0;

  logic        fgnt, fvalid, dgnt, dvalid, men, mwe, busy;
  logic [31:0] fdata, drdata, maddr, mwdata;
  logic [3:0]  mbe;
  logic        fgnt4, fvalid4, dgnt4, dvalid4, men4, mwe4, busy4;
  logic [31:0] fdata4, drdata4, maddr4, mwdata4;
  logic [3:0]  mbe4;

  logic [31:0] ram1 [64];
  logic [31:0] ram4 [64];
  logic [31:0] rd1;
  logic [31:0] rd4 [4];

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    if (i == 4) return 32'hDEADBEEF;
    return {8'hC3, 8'(i), 8'(~i), 8'h5A};
  endfunction

  function automatic logic [31:0] rand_addr();
    return {24'h0, 6'($urandom), 2'b00};
  endfunction

  mem_port_arbiter #(.WIDTH(32), .AW(32), .MEM_LAT(LAT1)) dut (
    .iClk(clk), .iRst(rst),
    .iFetchReq(f_req), .iFetchAddr(f_addr),
    .oFetchGnt(fgnt), .oFetchValid(fvalid), .oFetchData(fdata),
    .iDataReq(d_req), .iDataWe(d_we), .iDataAddr(d_addr),
    .iDataWdata(d_wdata), .iDataBe(d_be),
    .oDataGnt(dgnt), .oDataValid(dvalid), .oDataRdata(drdata),
    .oMemEn(men), .oMemWe(mwe), .oMemAddr(maddr), .oMemWdata(mwdata),
    .oMemBe(mbe), .iMemRdata(rd1), .oBusy(busy)
  );

  mem_port_arbiter #(.WIDTH(32), .AW(32), .MEM_LAT(4)) dut4 (
    .iClk(clk), .iRst(rst),
    .iFetchReq(f_req), .iFetchAddr(f_addr),
    .oFetchGnt(fgnt4), .oFetchValid(fvalid4), .oFetchData(fdata4),
    .iDataReq(d_req), .iDataWe(d_we), .iDataAddr(d_addr),
    .iDataWdata(d_wdata), .iDataBe(d_be),
    .oDataGnt(dgnt4), .oDataValid(dvalid4), .oDataRdata(drdata4),
    .oMemEn(men4), .oMemWe(mwe4), .oMemAddr(maddr4), .oMemWdata(mwdata4),
    .oMemBe(mbe4), .iMemRdata(rd4[3]), .oBusy(busy4)
  );

  // RAM for the MEM_LAT=1 instance: read data valid one cycle after enable.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) ram1[i] <= init_word(i);
    end else if (men && mwe) begin
      for (int b = 0; b < 4; b++)
        if (mbe[b]) ram1[maddr[7:2]][8*b +: 8] <= mwdata[8*b +: 8];
    end
    rd1 <= men ? ram1[maddr[7:2]] : $urandom;
  end

  // RAM for the MEM_LAT=4 instance: four-stage read pipeline.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) ram4[i] <= init_word(i);
    end else if (men4 && mwe4) begin
      for (int b = 0; b < 4; b++)
        if (mbe4[b]) ram4[maddr4[7:2]][8*b +: 8] <= mwdata4[8*b +: 8];
    end
    rd4[0] <= men4 ? ram4[maddr4[7:2]] : $urandom;
    rd4[1] <= rd4[0];
    rd4[2] <= rd4[1];
    rd4[3] <= rd4[2];
  end

  int checks = 0;
  int failures = 0;

  // Reference model state (transaction level).
  int          cyc = 0;
  int          free_at = 0;
  int          resp_cyc = -1;
  bit          granted = 0;
  bit          win_fetch = 0;
  bit          resp_fetch = 0;
  bit          resp_load = 0;
  bit          last_data = 1;
  bit          hold_f = 0;
  bit          hold_d = 0;
  bit          rand_mode = 0;
  logic        e_we = 0;
  logic [31:0] e_addr = '0;
  logic [31:0] e_wdata = '0;
  logic [3:0]  e_be = '0;
  logic [31:0] resp_data = '0;
  logic [31:0] exp_fdata = '0;
  logic [31:0] exp_rdata = '0;
  logic [31:0] ref_mem [64];

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%0b expected=%0b", tag, cyc, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // Advance one clock, update the model from the inputs that were just
  // sampled, check every output of the MEM_LAT=1 instance, then play the
  // requester role (drop or renew a granted request).
  task automatic cycle();
    bit          pf, pd, prst;
    logic        pwe;
    logic [31:0] pfa, pda, pdw;
    logic [3:0]  pbe;
    pf = f_req; pd = d_req; prst = rst;
    pwe = d_we; pfa = f_addr; pda = d_addr; pdw = d_wdata; pbe = d_be;
    @(posedge clk);
    #1;
    cyc++;
    granted = 0;
    if (prst) begin
      resp_cyc  = -1;
      free_at   = cyc;
      exp_fdata = '0;
      exp_rdata = '0;
      last_data = 1;
    end else if (cyc - 1 >= free_at && (pf || pd)) begin
      granted = 1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      win_fetch = (pf && pd) ? last_data : pf;
`else
      win_fetch = !pd;
`endif
      last_data  = !win_fetch;
      e_we       = win_fetch ? 1'b0 : pwe;
      e_addr     = win_fetch ? pfa : pda;
      e_wdata    = pdw;
      e_be       = win_fetch ? 4'hF : pbe;
      resp_cyc   = cyc + LAT1 + 1;
      free_at    = resp_cyc;
      resp_fetch = win_fetch;
      resp_load  = !e_we;
      if (e_we) begin
        for (int b = 0; b < 4; b++)
          if (e_be[b]) ref_mem[e_addr[7:2]][8*b +: 8] = e_wdata[8*b +: 8];
      end else begin
        resp_data = ref_mem[e_addr[7:2]];
      end
    end
    if (cyc == resp_cyc && resp_load) begin
      if (resp_fetch) exp_fdata = resp_data;
      else            exp_rdata = resp_data;
    end

    chk1("fetch_gnt", fgnt, granted && win_fetch);
    chk1("data_gnt", dgnt, granted && !win_fetch);
    chk1("mem_en", men, granted);
    chk1("mem_we", mwe, granted && e_we);
    chk32("mem_addr", maddr, granted ? e_addr : 32'd0);
    chk32("mem_be", 32'(mbe), granted ? 32'(e_be) : 32'd0);
    if (!granted || e_we) chk32("mem_wdata", mwdata, granted ? e_wdata : 32'd0);
    chk1("fetch_valid", fvalid, (cyc == resp_cyc) && resp_fetch);
    chk1("data_valid", dvalid, (cyc == resp_cyc) && !resp_fetch);
    chk32("fetch_data", fdata, exp_fdata);
    chk32("data_rdata", drdata, exp_rdata);
    chk1("busy", busy, cyc <= resp_cyc);

    if (granted && win_fetch && !hold_f) begin
      if (rand_mode && $urandom_range(3) == 0) f_addr = rand_addr();
      else f_req = 1'b0;
    end
    if (granted && !win_fetch && !hold_d) begin
      if (rand_mode && $urandom_range(3) == 0) begin
        d_we = 1'($urandom_range(1)); d_addr = rand_addr();
        d_wdata = $urandom; d_be = 4'($urandom);
      end else begin
        d_req = 1'b0;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; mem_init = 1'b1;
    f_req = 1'b0; d_req = 1'b0; hold_f = 0; hold_d = 0;
    for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
    cycle();
    cycle();
    rst = 1'b0; mem_init = 1'b0;
  endtask

  initial begin
    int n;

    // Reset state
    do_reset();
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_mem_en", men, 1'b0);
    chk32("rst_fdata", fdata, 32'd0);
    chk32("rst_rdata", drdata, 32'd0);
    chk1("rst_busy4", busy4, 1'b0);

    // Single fetch from 0x10
    f_req = 1'b1; f_addr = 32'h10;
    cycle();
    chk1("sf_gnt", fgnt, 1'b1);
    chk1("sf_en", men, 1'b1);
    chk32("sf_addr", maddr, 32'h10);
    cycle();
    chk1("sf_no_valid_early", fvalid, 1'b0);
    cycle();
    chk1("sf_valid", fvalid, 1'b1);
    chk32("sf_data", fdata, 32'hDEADBEEF);
    cycle();

    // Store 0x12345678 with be=0x3 to 0x20
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'h12345678; d_be = 4'h3;
    cycle();
    chk1("st_we", mwe, 1'b1);
    chk32("st_be", 32'(mbe), 32'h3);
    chk32("st_wdata", mwdata, 32'h12345678);
    cycle();
    chk1("st_we_once", mwe, 1'b0);
    cycle();
    chk1("st_valid", dvalid, 1'b1);
    chk32("st_rdata_held", drdata, 32'd0);
    cycle();

    // Read back the partially written word
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
    repeat (3) cycle();
    chk32("st_readback", drdata, {init_word(8)[31:16], 16'h5678});
    cycle();

`ifndef MEM_ARB_ROUND_ROBIN_EN
    // Simultaneous requests, fixed priority
    f_req = 1'b1; f_addr = 32'h30;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
    cycle();
    chk1("sim_data_first", dgnt, 1'b1);
    chk1("sim_fetch_waits", fgnt, 1'b0);
    cycle();
    cycle();
    chk1("sim_no_gnt_in_resp", fgnt, 1'b0);
    cycle();
    chk1("sim_fetch_second", fgnt, 1'b1);
    repeat (3) cycle();
`else
    // Simultaneous requests held continuously, round robin
    do_reset();
    hold_f = 1; hold_d = 1;
    f_req = 1'b1; f_addr = 32'h10;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h24;
    n = 0;
    for (int k = 0; k < 20 && n < 4; k++) begin
      cycle();
      if (fgnt || dgnt) begin
        chk1($sformatf("rr_order%0d", n), fgnt, (n % 2) == 0);
        n++;
      end
    end
    chk32("rr_count", 32'(n), 32'd4);
    hold_f = 0; hold_d = 0; f_req = 1'b0; d_req = 1'b0;
    repeat (4) cycle();
`endif

    // Reset during WAIT
    f_req = 1'b1; f_addr = 32'h14;
    cycle();
    chk1("rm_gnt", fgnt, 1'b1);
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk1("rm_no_valid", fvalid, 1'b0);
    chk1("rm_busy_low", busy, 1'b0);
    cycle();
    chk1("rm_still_quiet", fvalid, 1'b0);
    f_req = 1'b1; f_addr = 32'h10;
    repeat (3) cycle();
    chk1("rm_new_valid", fvalid, 1'b1);
    chk32("rm_new_data", fdata, 32'hDEADBEEF);
    cycle();

    // MEM_LAT=4 load on the second instance
    do_reset();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10;
    for (int k = 1; k <= 8; k++) begin
      cycle();
      chk1($sformatf("l4_gnt%0d", k), dgnt4, k == 1);
      chk1($sformatf("l4_valid%0d", k), dvalid4, k == 6);
      chk1($sformatf("l4_busy%0d", k), busy4, k <= 6);
      chk1("l4_fgnt", fgnt4, 1'b0);
      chk1("l4_fvalid", fvalid4, 1'b0);
      if (k == 6) chk32("l4_data", drdata4, 32'hDEADBEEF);
    end
    chk32("l4_fdata", fdata4, 32'd0);

    // Randomized traffic against the model
    do_reset();
    rand_mode = 1;
    for (int k = 0; k < 400; k++) begin
      if (!f_req && $urandom_range(2) == 0) begin
        f_req = 1'b1; f_addr = rand_addr();
      end
      if (!d_req && $urandom_range(2) == 0) begin
        d_req = 1'b1; d_we = 1'($urandom_range(1)); d_addr = rand_addr();
        d_wdata = $urandom; d_be = 4'($urandom);
      end
      cycle();
    end
    rand_mode = 0;
    f_req = 1'b0; d_req = 1'b0;
    repeat (6) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
